// File: rtl/out_display.sv
// Captures CPU output bytes, converts them to three BCD digits with a sequential
// double-dabble engine, and scans a 3-digit active-low 7-segment display.
// Optional: define OUT_DISP_LZB_EN for leading-zero blanking.
module out_display #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data,
    input  logic       i_load,
    output logic [7:0] o_seg,
    output logic [2:0] o_dig_en,
    output logic       o_busy
);

    localparam int unsigned DAT_W = 8;
    localparam int unsigned BCD_W = 12;
    localparam int unsigned CNT_W = $clog2(REFRESH_DIV);

    typedef enum logic [1:0] {S_IDLE, S_CONV, S_DONE} state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic [DAT_W-1:0]   r_bin;
    logic [BCD_W-1:0]   r_bcd;
    logic [BCD_W-1:0]   w_bcd_adj;
    logic [2:0]         r_iter;
    logic               r_pend;
    logic [DAT_W-1:0]   r_pend_data;
    logic [3:0]         r_disp_h;
    logic [3:0]         r_disp_t;
    logic [3:0]         r_disp_u;
    logic [CNT_W-1:0]   r_ref_cnt;
    logic [1:0]         r_dig_idx;

    logic               w_start;
    logic [DAT_W-1:0]   w_start_data;
    logic               w_shift;
    logic               w_commit;
    logic               w_pend_set;
    logic               w_ref_wrap;
    logic [3:0]         w_dig;
    logic               w_blank;
    logic [2:0]         w_dig_en_nxt;
    logic [7:0]         w_seg_nxt;

    function automatic logic [6:0] seg_pat(input logic [3:0] d);
        case (d)
            4'd0:    seg_pat = 7'h40;
            4'd1:    seg_pat = 7'h79;
            4'd2:    seg_pat = 7'h24;
            4'd3:    seg_pat = 7'h30;
            4'd4:    seg_pat = 7'h19;
            4'd5:    seg_pat = 7'h12;
            4'd6:    seg_pat = 7'h02;
            4'd7:    seg_pat = 7'h78;
            4'd8:    seg_pat = 7'h00;
            4'd9:    seg_pat = 7'h10;
            default: seg_pat = 7'h7F;
        endcase
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next_state;
    end

    // A load arriving in DONE is the newest value, so it takes priority over the pending byte.
    always_comb begin
        w_next_state = r_state;
        w_start      = 1'b0;
        w_start_data = i_data;
        w_shift      = 1'b0;
        w_commit     = 1'b0;
        w_pend_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_load) begin
                    w_start      = 1'b1;
                    w_next_state = S_CONV;
                end
            end
            S_CONV: begin
                w_shift    = 1'b1;
                w_pend_set = i_load;
                if (r_iter == 3'd7) w_next_state = S_DONE;
            end
            S_DONE: begin
                w_commit = 1'b1;
                if (i_load) begin
                    w_start      = 1'b1;
                    w_next_state = S_CONV;
                end else if (r_pend) begin
                    w_start      = 1'b1;
                    w_start_data = r_pend_data;
                    w_next_state = S_CONV;
                end else begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        w_bcd_adj = r_bcd;
        for (int k = 0; k < 3; k++) begin
            if (r_bcd[4*k +: 4] >= 4'd5) w_bcd_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_bin       <= '0;
            r_bcd       <= '0;
            r_iter      <= '0;
            r_pend      <= 1'b0;
            r_pend_data <= '0;
            r_disp_h    <= '0;
            r_disp_t    <= '0;
            r_disp_u    <= '0;
            o_busy      <= 1'b0;
        end else begin
            o_busy <= (w_next_state != S_IDLE);
            if (w_start) begin
                r_bin  <= w_start_data;
                r_bcd  <= '0;
                r_iter <= '0;
            end else if (w_shift) begin
                r_bcd  <= {w_bcd_adj[BCD_W-2:0], r_bin[DAT_W-1]};
                r_bin  <= {r_bin[DAT_W-2:0], 1'b0};
                r_iter <= r_iter + 3'd1;
            end
            if (w_pend_set) begin
                r_pend      <= 1'b1;
                r_pend_data <= i_data;
            end else if (w_commit) begin
                r_pend <= 1'b0;
            end
            if (w_commit) begin
                r_disp_h <= r_bcd[11:8];
                r_disp_t <= r_bcd[7:4];
                r_disp_u <= r_bcd[3:0];
            end
        end
    end

    assign w_ref_wrap = (r_ref_cnt == CNT_W'(REFRESH_DIV - 1));

    always_comb begin
        w_dig        = r_disp_u;
        w_blank      = 1'b0;
        w_dig_en_nxt = 3'b110;
        case (r_dig_idx)
            2'd1: begin
                w_dig        = r_disp_t;
                w_dig_en_nxt = 3'b101;
`ifdef OUT_DISP_LZB_EN
                w_blank      = (r_disp_h == 4'd0) && (r_disp_t == 4'd0);
`endif
            end
            2'd2: begin
                w_dig        = r_disp_h;
                w_dig_en_nxt = 3'b011;
`ifdef OUT_DISP_LZB_EN
                w_blank      = (r_disp_h == 4'd0);
`endif
            end
            default: ;
        endcase
        w_seg_nxt = w_blank ? 8'hFF : {1'b1, seg_pat(w_dig)};
    end

    // Scan timing runs free of the converter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ref_cnt <= '0;
            r_dig_idx <= '0;
            o_seg     <= 8'hFF;
            o_dig_en  <= 3'b111;
        end else begin
            o_seg    <= w_seg_nxt;
            o_dig_en <= w_dig_en_nxt;
            if (w_ref_wrap) begin
                r_ref_cnt <= '0;
                r_dig_idx <= (r_dig_idx == 2'd2) ? 2'd0 : r_dig_idx + 2'd1;
            end else begin
                r_ref_cnt <= r_ref_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_out_display.sv
// Directed bench for out_display: reset, scan order, conversion latency,
// pending-load handling, mid-conversion reset and a full 0..255 sweep.
module tb_out_display;

    logic       i_clk;
    logic       i_rst;
    logic [7:0] i_data;
    logic       i_load;
    logic [7:0] o_seg;
    logic [2:0] o_dig_en;
    logic       o_busy;

    int n_checks = 0;
    int n_errors = 0;

    out_display #(.REFRESH_DIV(4)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_data   (i_data),
        .i_load   (i_load),
        .o_seg    (o_seg),
        .o_dig_en (o_dig_en),
        .o_busy   (o_busy)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    function automatic logic [7:0] pat(input int d);
        case (d)
            0: pat = 8'hC0;  1: pat = 8'hF9;  2: pat = 8'hA4;  3: pat = 8'hB0;
            4: pat = 8'h99;  5: pat = 8'h92;  6: pat = 8'h82;  7: pat = 8'hF8;
            8: pat = 8'h80;  9: pat = 8'h90;  default: pat = 8'h00;
        endcase
    endfunction

    // Expected segment byte for value v on the digit selected by den.
    function automatic logic [7:0] exp_seg(input int v, input logic [2:0] den);
        int h, t, u;
        bit lzb;
        h = v / 100;
        t = (v / 10) % 10;
        u = v % 10;
`ifdef OUT_DISP_LZB_EN
        lzb = 1'b1;
`else
        lzb = 1'b0;
`endif
        case (den)
            3'b110:  exp_seg = pat(u);
            3'b101:  exp_seg = (lzb && h == 0 && t == 0) ? 8'hFF : pat(t);
            3'b011:  exp_seg = (lzb && h == 0) ? 8'hFF : pat(h);
            default: exp_seg = 8'h00;
        endcase
    endfunction

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_den_valid();
        logic ok;
        ok = (o_dig_en == 3'b110) || (o_dig_en == 3'b101) || (o_dig_en == 3'b011);
        chk("dig_en_onehot", 8'(ok), 8'd1);
    endtask

    task automatic check_display(input int v, input string tag);
        for (int c = 0; c < 13; c++) begin
            chk_den_valid();
            chk($sformatf("%s_v%0d_en%b", tag, v, o_dig_en), o_seg, exp_seg(v, o_dig_en));
            step();
        end
    endtask

    task automatic wait_idle(input string tag);
        for (int c = 0; c < 20; c++) begin
            if (!o_busy) break;
            step();
        end
        chk({tag, "_idle_timeout"}, 8'(o_busy), 8'd0);
    endtask

    task automatic load(input logic [7:0] d);
        i_data = d;
        i_load = 1'b1;
        step();
        i_load = 1'b0;
    endtask

    initial begin
        logic [2:0] exp_en;
        i_rst  = 1'b1;
        i_load = 1'b0;
        i_data = 8'd0;
        step(); step(); step();
        chk("rst_seg", o_seg, 8'hFF);
        chk("rst_dig_en", 8'(o_dig_en), 8'(3'b111));
        chk("rst_busy", 8'(o_busy), 8'd0);

        // Idle scan: each digit held for 4 cycles in order units, tens, hundreds.
        i_rst = 1'b0;
        step();
        for (int k = 0; k < 24; k++) begin
            case ((k / 4) % 3)
                0:       exp_en = 3'b110;
                1:       exp_en = 3'b101;
                default: exp_en = 3'b011;
            endcase
            chk($sformatf("scan_en_k%0d", k), 8'(o_dig_en), 8'(exp_en));
            chk($sformatf("scan_seg_k%0d", k), o_seg, exp_seg(0, exp_en));
            chk("scan_busy", 8'(o_busy), 8'd0);
            step();
        end

        // 255: busy for exactly 9 cycles after the load cycle.
        load(8'd255);
        for (int k = 1; k <= 9; k++) begin
            chk($sformatf("busy255_n%0d", k), 8'(o_busy), 8'd1);
            step();
        end
        chk("busy255_n10", 8'(o_busy), 8'd0);
        step();
        check_display(255, "d255");

        load(8'd7);
        wait_idle("d7");
        step();
        check_display(7, "d7");

        // 100, then 42 and 9 while busy: 100 shown in between, 9 wins.
        load(8'd100);
        step(); step();
        load(8'd42);
        step();
        load(8'd9);
        for (int p = 6; p <= 19; p++) begin
            chk($sformatf("pend_busy_n%0d", p), 8'(o_busy), (p <= 18) ? 8'd1 : 8'd0);
            if (p >= 11) chk($sformatf("pend_mid_n%0d", p), o_seg, exp_seg(100, o_dig_en));
            step();
        end
        check_display(9, "pend_final");

        // Reset mid-conversion.
        load(8'd128);
        step(); step(); step();
        i_rst = 1'b1;
        step();
        i_rst = 1'b0;
        chk("mrst_seg", o_seg, 8'hFF);
        chk("mrst_dig_en", 8'(o_dig_en), 8'(3'b111));
        chk("mrst_busy", 8'(o_busy), 8'd0);
        step();
        chk("mrst_first_en", 8'(o_dig_en), 8'(3'b110));
        chk("mrst_first_seg", o_seg, 8'hC0);
        check_display(0, "mrst");
        chk("mrst_busy_after", 8'(o_busy), 8'd0);

        // Full sweep.
        for (int v = 0; v < 256; v++) begin
            load(8'(v));
            chk($sformatf("sweep_busy_v%0d", v), 8'(o_busy), 8'd1);
            wait_idle("sweep");
            step();
            check_display(v, "sweep");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
